// File: rtl/dm_acc_downstream_pipe_if.sv
// Update/read/control bundle for the downstream per-client accumulator RAM.
interface dm_acc_downstream_pipe_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 10
);
    logic              acc_valid;
    logic              acc_ready;
    logic [IDX_W-1:0]  acc_idx;
    logic [DATA_W-1:0] acc_data;
    logic              rd_valid;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_data_valid;
    logic [DATA_W-1:0] rd_data;
    logic              clr_all;
    logic              init_busy;
    logic              sat_pulse;

    modport master (
        output acc_valid, acc_idx, acc_data, rd_valid, rd_idx, clr_all,
        input  acc_ready, rd_data_valid, rd_data, init_busy, sat_pulse
    );

    modport slave (
        input  acc_valid, acc_idx, acc_data, rd_valid, rd_idx, clr_all,
        output acc_ready, rd_data_valid, rd_data, init_busy, sat_pulse
    );
endinterface

// File: rtl/dm_acc_downstream_pipe.sv
// Per-client saturating accumulator RAM: 2-stage RMW with forwarding and a zeroing sweep.
// Define DS_ACC_CLR_ON_READ_EN to make every read clear the entry it returns.
module dm_acc_downstream_pipe #(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 1024,
    parameter int                IDX_W    = $clog2(DEPTH),
    parameter logic [DATA_W-1:0] LIMIT    = DATA_W'(32'h0000_FFAA),
    parameter int                SAT_MODE = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    dm_acc_downstream_pipe_if.slave   bus
);

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              s1_valid_q, s1_valid_d;
    logic              s1_zero_q, s1_zero_d;
    logic [IDX_W-1:0]  s1_idx_q, s1_idx_d;
    logic [DATA_W-1:0] s1_delta_q, s1_delta_d;
    logic [DATA_W-1:0] s1_mem_q, s1_mem_d;
    logic              s2_valid_q, s2_valid_d;
    logic [IDX_W-1:0]  s2_idx_q, s2_idx_d;
    logic [DATA_W-1:0] s2_val_q, s2_val_d;
    logic              rd_data_valid_q, rd_data_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              sat_pulse_q, sat_pulse_d;

    logic              acc_fire, rd_fire, sat_hit, wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] operand, result, wr_data;
    logic [DATA_W:0]   sum;
`ifdef DS_ACC_CLR_ON_READ_EN
    logic              clr_en;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (bus.clr_all) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // S1 operand priority: a same-edge clear beats the previous commit, which beats the RAM copy.
    always_comb begin
        acc_fire = bus.acc_valid && (state_q == ST_RUN);
        rd_fire  = bus.rd_valid && (state_q == ST_RUN);

        if (s1_zero_q)
            operand = '0;
        else if (s2_valid_q && (s2_idx_q == s1_idx_q))
            operand = s2_val_q;
        else
            operand = s1_mem_q;

        sum     = {1'b0, operand} + {1'b0, s1_delta_q};
        sat_hit = (sum >= {1'b0, LIMIT});
        if (!sat_hit)
            result = sum[DATA_W-1:0];
        else if (SAT_MODE != 0)
            result = LIMIT - 1'b1;
        else
            result = operand;

        wr_en   = (state_q == ST_INIT) || s1_valid_q;
        wr_idx  = (state_q == ST_INIT) ? cnt_q : s1_idx_q;
        wr_data = (state_q == ST_INIT) ? '0 : result;

        s1_valid_d = acc_fire;
        s1_idx_d   = bus.acc_idx;
        s1_delta_d = bus.acc_data;
        s1_mem_d   = mem_q[bus.acc_idx];
`ifdef DS_ACC_CLR_ON_READ_EN
        clr_en     = rd_fire;
        s1_zero_d  = rd_fire && (bus.rd_idx == bus.acc_idx);
`else
        s1_zero_d  = 1'b0;
`endif

        s2_valid_d  = s1_valid_q;
        s2_idx_d    = s1_idx_q;
        s2_val_d    = result;
        sat_pulse_d = s1_valid_q && sat_hit;

        rd_data_valid_d = rd_fire;
        rd_data_d       = rd_data_q;
        if (rd_fire) begin
            if (s1_valid_q && (s1_idx_q == bus.rd_idx))
                rd_data_d = result;
            else
                rd_data_d = mem_q[bus.rd_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_INIT;
            cnt_q           <= '0;
            s1_valid_q      <= 1'b0;
            s1_zero_q       <= 1'b0;
            s1_idx_q        <= '0;
            s1_delta_q      <= '0;
            s1_mem_q        <= '0;
            s2_valid_q      <= 1'b0;
            s2_idx_q        <= '0;
            s2_val_q        <= '0;
            rd_data_valid_q <= 1'b0;
            rd_data_q       <= '0;
            sat_pulse_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            s1_valid_q      <= s1_valid_d;
            s1_zero_q       <= s1_zero_d;
            s1_idx_q        <= s1_idx_d;
            s1_delta_q      <= s1_delta_d;
            s1_mem_q        <= s1_mem_d;
            s2_valid_q      <= s2_valid_d;
            s2_idx_q        <= s2_idx_d;
            s2_val_q        <= s2_val_d;
            rd_data_valid_q <= rd_data_valid_d;
            rd_data_q       <= rd_data_d;
            sat_pulse_q     <= sat_pulse_d;
        end
    end

    // No reset on the array; the sweep zeroes it. A read-clear lands last so it wins.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx] <= wr_data;
`ifdef DS_ACC_CLR_ON_READ_EN
        if (clr_en) mem_q[bus.rd_idx] <= '0;
`endif
    end

    assign bus.acc_ready     = (state_q == ST_RUN);
    assign bus.init_busy     = (state_q == ST_INIT);
    assign bus.rd_data_valid = rd_data_valid_q;
    assign bus.rd_data       = rd_data_q;
    assign bus.sat_pulse     = sat_pulse_q;

endmodule

// File: tb/tb_dm_acc_downstream_pipe.sv
// Self-checking bench for dm_acc_downstream_pipe: vector table, hand sequences and a
// transaction-ordered reference model driven by random traffic.
module tb_dm_acc_downstream_pipe;

    localparam int          DATA_W   = 32;
    localparam int          DEPTH    = 1024;
    localparam int          IDX_W    = 10;
    localparam int          SAT_MODE = 0;
    localparam logic [31:0] LIMIT    = 32'h0000_FFAA;
    localparam logic [31:0] SAT_READ = (SAT_MODE != 0) ? 32'h0000_FFA9 : 32'h0000_FFA0;
`ifdef DS_ACC_CLR_ON_READ_EN
    localparam bit          CLR_ON_READ = 1'b1;
`else
    localparam bit          CLR_ON_READ = 1'b0;
`endif
    localparam logic [31:0] REREAD = CLR_ON_READ ? 32'd0 : 32'd2;

    typedef struct {
        bit          av;
        int          ai;
        logic [31:0] ad;
        bit          rv;
        int          ri;
        bit          xrdv;
        logic [31:0] xrd;
        bit          xsat;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    // Reference model: entry values plus the one update waiting to be applied.
    longint unsigned mdl [DEPTH];
    int              phase;
    int              init_left;
    bit              pend_v;
    int              pend_idx;
    longint unsigned pend_data;
    bit              exp_rdv;
    bit              exp_sat;
    longint unsigned exp_rd;

    dm_acc_downstream_pipe_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

    dm_acc_downstream_pipe #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W), .LIMIT(LIMIT), .SAT_MODE(SAT_MODE)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint unsigned act, input longint unsigned req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic resetModel();
        phase     = 0;
        init_left = DEPTH;
        pend_v    = 1'b0;
        exp_rdv   = 1'b0;
        exp_sat   = 1'b0;
        exp_rd    = 0;
        foreach (mdl[i]) mdl[i] = 0;
    endtask

    // Event order at one edge: the update accepted last edge lands, then the read samples,
    // then a new update is queued; phase 0 = sweeping, 1 = running, 2 = draining.
    task automatic modelEdge();
        longint unsigned s;
        exp_sat = 1'b0;
        exp_rdv = 1'b0;
        if (pend_v) begin
            s = mdl[pend_idx] + pend_data;
            if (s >= LIMIT) begin
                exp_sat = 1'b1;
                if (SAT_MODE != 0) mdl[pend_idx] = LIMIT - 1;
            end else begin
                mdl[pend_idx] = s;
            end
            pend_v = 1'b0;
        end
        if (phase == 1) begin
            if (bus.rd_valid) begin
                exp_rdv = 1'b1;
                exp_rd  = mdl[bus.rd_idx];
                if (CLR_ON_READ) mdl[bus.rd_idx] = 0;
            end
            if (bus.acc_valid) begin
                pend_v    = 1'b1;
                pend_idx  = int'(bus.acc_idx);
                pend_data = bus.acc_data;
            end
        end
        case (phase)
            0: begin
                init_left--;
                if (init_left == 0) phase = 1;
            end
            1: if (bus.clr_all) phase = 2;
            default: begin
                phase     = 0;
                init_left = DEPTH;
                foreach (mdl[i]) mdl[i] = 0;
            end
        endcase
    endtask

    task automatic compareAll();
        checkOutput("acc_ready", bus.acc_ready, (phase == 1) ? 1 : 0);
        checkOutput("init_busy", bus.init_busy, (phase == 0) ? 1 : 0);
        checkOutput("rd_data_valid", bus.rd_data_valid, exp_rdv);
        checkOutput("rd_data", bus.rd_data, exp_rd);
        checkOutput("sat_pulse", bus.sat_pulse, exp_sat);
    endtask

    task automatic applyStimulus(input bit av, input int ai, input longint unsigned ad,
                                 input bit rv, input int ri, input bit ca);
        bus.acc_valid = av;
        bus.acc_idx   = IDX_W'(ai);
        bus.acc_data  = DATA_W'(ad);
        bus.rd_valid  = rv;
        bus.rd_idx    = IDX_W'(ri);
        bus.clr_all   = ca;
        modelEdge();
        @(posedge clk);
        #1;
        compareAll();
    endtask

    task automatic randomStep(input bit allow_clr);
        int r;
        longint unsigned d;
        r = int'($urandom_range(0, 9));
        if (r == 0)     d = longint'($urandom);
        else if (r < 3) d = longint'($urandom_range(0, 32'h8000));
        else            d = longint'($urandom_range(0, 255));
        applyStimulus($urandom_range(0, 1) == 1, int'($urandom_range(0, 7)), d,
                      $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
                      allow_clr && ($urandom_range(0, 1499) == 0));
    endtask

    task automatic measureSweep(output int n);
        n = 0;
        for (int k = 0; k < 3 * DEPTH; k++) begin
            if (bus.acc_ready) break;
            if (bus.init_busy) n++;
            randomStep(1'b0);
        end
        checkOutput("sweep_ends", bus.acc_ready, 1);
    endtask

    task automatic doReset();
        bus.acc_valid = 1'b0;
        bus.acc_idx   = '0;
        bus.acc_data  = '0;
        bus.rd_valid  = 1'b0;
        bus.rd_idx    = '0;
        bus.clr_all   = 1'b0;
        rst_n = 1'b0;
        resetModel();
        @(posedge clk);
        #1;
        compareAll();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("[TB] FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        vec_t vecs [15];
        int   n;
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;

        vecs[0]  = '{1'b1, 3, 32'd5,        1'b0, 0, 1'b0, 32'd0,  1'b0};
        vecs[1]  = '{1'b1, 3, 32'd7,        1'b0, 0, 1'b0, 32'd0,  1'b0};
        vecs[2]  = '{1'b1, 3, 32'd9,        1'b0, 0, 1'b0, 32'd0,  1'b0};
        vecs[3]  = '{1'b0, 0, 32'd0,        1'b1, 3, 1'b1, 32'd21, 1'b0};
        vecs[4]  = '{1'b1, 4, 32'h0000_FFA0, 1'b0, 0, 1'b0, 32'd0,  1'b0};
        vecs[5]  = '{1'b1, 4, 32'h0000_0010, 1'b0, 0, 1'b0, 32'd0,  1'b0};
        vecs[6]  = '{1'b0, 0, 32'd0,        1'b0, 0, 1'b0, 32'd0,  1'b1};
        vecs[7]  = '{1'b0, 0, 32'd0,        1'b1, 4, 1'b1, SAT_READ, 1'b0};
        vecs[8]  = '{1'b0, 0, 32'd0,        1'b0, 0, 1'b0, 32'd0,  1'b0};
        vecs[9]  = '{1'b1, 8, 32'd2,        1'b0, 0, 1'b0, 32'd0,  1'b0};
        vecs[10] = '{1'b0, 0, 32'd0,        1'b1, 8, 1'b1, 32'd2,  1'b0};
        vecs[11] = '{1'b0, 0, 32'd0,        1'b1, 8, 1'b1, REREAD, 1'b0};
        vecs[12] = '{1'b1, 9, 32'h0000_FFA9, 1'b0, 0, 1'b0, 32'd0,  1'b0};
        vecs[13] = '{1'b0, 0, 32'd0,        1'b0, 0, 1'b0, 32'd0,  1'b0};
        vecs[14] = '{1'b0, 0, 32'd0,        1'b1, 9, 1'b1, 32'h0000_FFA9, 1'b0};

        #3;
        doReset();

        for (int i = 0; i < DEPTH - 1; i++) randomStep(1'b0);
        checkOutput("init_busy_cycle1023", bus.init_busy, 1);
        checkOutput("acc_ready_cycle1023", bus.acc_ready, 0);
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b0);
        checkOutput("init_busy_cycle1024", bus.init_busy, 0);
        checkOutput("acc_ready_cycle1024", bus.acc_ready, 1);

        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 0, 0, 1'b1, i, 1'b0);
        checkOutput("read_all_last", bus.rd_data, 0);
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b0);

        for (int v = 0; v < 15; v++) begin
            applyStimulus(vecs[v].av, vecs[v].ai, longint'(vecs[v].ad), vecs[v].rv, vecs[v].ri, 1'b0);
            checkOutput($sformatf("vec%0d_rdv", v), bus.rd_data_valid, vecs[v].xrdv);
            if (vecs[v].xrdv) checkOutput($sformatf("vec%0d_rd", v), bus.rd_data, vecs[v].xrd);
            checkOutput($sformatf("vec%0d_sat", v), bus.sat_pulse, vecs[v].xsat);
        end

        applyStimulus(1'b1, 5, 'h55, 1'b0, 0, 1'b0);
        applyStimulus(1'b0, 0, 0, 1'b1, 5, 1'b0);
        checkOutput("rd_idx5", bus.rd_data, 'h55);
        applyStimulus(1'b1, 1, 6, 1'b0, 0, 1'b1);
        checkOutput("drain_acc_ready", bus.acc_ready, 0);
        checkOutput("drain_init_busy", bus.init_busy, 0);
        measureSweep(n);
        checkOutput("sweep_len_after_clr", n, DEPTH);
        applyStimulus(1'b0, 0, 0, 1'b1, 1, 1'b0);
        checkOutput("rd_idx1_after_clr_valid", bus.rd_data_valid, 1);
        checkOutput("rd_idx1_after_clr", bus.rd_data, 0);

        applyStimulus(1'b1, 6, 'h66, 1'b0, 0, 1'b0);
        applyStimulus(1'b0, 0, 0, 1'b1, 6, 1'b0);
        checkOutput("rd_idx6", bus.rd_data, 'h66);
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b1);
        for (int i = 0; i < 300; i++) randomStep(1'b0);
        rst_n = 1'b0;
        #1;
        resetModel();
        compareAll();
        checkOutput("midsweep_rst_rd_data", bus.rd_data, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        measureSweep(n);
        checkOutput("sweep_len_after_rst", n, DEPTH);

        for (int i = 0; i < 2500; i++) randomStep(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
